// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register map,
// controller state encoding and STATUS register field layout.
package irq_pkg;

    // Register select values on cfg_addr
    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_CLAIM   = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    // Raise/claim/end-of-interrupt sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAISE   = 2'd1,
        CLAIMED = 2'd2
    } irq_state_t;

    // Width of a source id as reported by CLAIM and STATUS (index + 1, 0 = none)
    localparam int ID_W = 6;

    // STATUS register layout
    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_STATE_W   = 2;
    localparam int STAT_ID_LSB    = 2;
    localparam int STAT_IRQ_BIT   = 8;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous interrupt source followed by
// a third flop used for rising-edge detection. The rise output is a
// single-cycle pulse in the clk domain.
module irq_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic src_in,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Synchroniser chain plus delay stage for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= src_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: collects edge-triggered sources into a pending
// vector, masks them, picks the lowest-index eligible source and drives a
// single registered irq line through a raise/claim/eoi handshake.
//
// Register port: cfg_we and cfg_re are single-cycle strobes sampled on the
// rising clk edge with cfg_addr/cfg_wdata; a write wins over a simultaneous
// read. Read data appears on cfg_rdata after the edge that sampled cfg_re
// and holds until the next read. A CLAIM read's side effects land on that
// same edge.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src,
    input  logic [1:0]         cfg_addr,
    input  logic               cfg_we,
    input  logic               cfg_re,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    input  logic               eoi,
    output logic               irq
);

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] w1c_clr;
    logic [NUM_SRC-1:0] claim_clr;

    irq_state_t state;
    irq_state_t next_state;
    logic       irq_next;

    logic [ID_W-1:0] in_service_id;
    logic [ID_W-1:0] claim_id;
    logic [4:0]      winner;
    logic            any_eligible;

    logic        wr_mask;
    logic        wr_pend;
    logic        rd_en;
    logic        rd_claim;
    logic        claim_take;
    logic [31:0] status_word;
    logic [31:0] rd_mux;

    // Upper write-data bits have no register behind them
    logic unused_wdata;
    assign unused_wdata = ^cfg_wdata[31:NUM_SRC];

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_src
            irq_sync_edge u_sync (
                .clk    (clk),
                .reset  (reset),
                .src_in (src[g]),
                .rise   (rise[g])
            );
        end
    endgenerate

    assign wr_mask  = cfg_we && (cfg_addr == ADDR_MASK);
    assign wr_pend  = cfg_we && (cfg_addr == ADDR_PENDING);
    assign rd_en    = cfg_re && !cfg_we;
    assign rd_claim = rd_en && (cfg_addr == ADDR_CLAIM);
    assign eligible = pending & mask;
    assign w1c_clr  = wr_pend ? cfg_wdata[NUM_SRC-1:0] : '0;

    // Fixed priority: scan high to low so the lowest set index is left last
    always_comb begin
        winner       = '0;
        any_eligible = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner       = i[4:0];
                any_eligible = 1'b1;
            end
        end
    end

    assign claim_id = any_eligible ? ({1'b0, winner} + 6'd1) : '0;

    // Next-state and irq decode; only a claim in RAISE has side effects
    always_comb begin
        next_state = state;
        claim_take = 1'b0;
        case (state)
            IDLE: begin
                if (any_eligible) begin
                    next_state = RAISE;
                end
            end
            RAISE: begin
                if (rd_claim && any_eligible) begin
                    next_state = CLAIMED;
                    claim_take = 1'b1;
                end else if (!any_eligible) begin
                    next_state = IDLE;
                end
            end
            CLAIMED: begin
                if (eoi) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        irq_next = (next_state == RAISE);
    end

    // One-hot clear of the claimed source's pending bit
    always_comb begin
        claim_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_clr[i] = claim_take && (winner == i[4:0]);
        end
    end

    // State register and registered irq level
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            irq   <= 1'b0;
        end else begin
            state <= next_state;
            irq   <= irq_next;
        end
    end

    // Pending latch: a fresh edge beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~(w1c_clr | claim_clr)) | rise;
        end
    end

    // Software mask register
    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= '0;
        end else if (wr_mask) begin
            mask <= cfg_wdata[NUM_SRC-1:0];
        end
    end

    // In-service id: set by a successful claim, cleared by end-of-interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            in_service_id <= '0;
        end else if (claim_take) begin
            in_service_id <= claim_id;
        end else if ((state == CLAIMED) && eoi) begin
            in_service_id <= '0;
        end
    end

    // STATUS word assembly
    always_comb begin
        status_word = '0;
        status_word[STAT_STATE_LSB +: STAT_STATE_W] = state;
        status_word[STAT_ID_LSB +: ID_W]            = in_service_id;
        status_word[STAT_IRQ_BIT]                   = irq;
    end

    // Read data select
    always_comb begin
        rd_mux = '0;
        case (cfg_addr)
            ADDR_MASK:    rd_mux = {{(32 - NUM_SRC){1'b0}}, mask};
            ADDR_PENDING: rd_mux = {{(32 - NUM_SRC){1'b0}}, pending};
            ADDR_CLAIM:   rd_mux = {{(32 - ID_W){1'b0}}, claim_id};
            ADDR_STATUS:  rd_mux = status_word;
            default:      rd_mux = '0;
        endcase
    end

    // Registered read data, held between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_rdata <= '0;
        end else if (rd_en) begin
            cfg_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Testbench for irq_controller: reset checks, a table of per-cycle vectors
// covering claim, priority, masking, W1C and set-beats-clear, then
// hand-written reset-mid-handshake and randomised priority sequences.
module tb_irq_controller;
    import irq_pkg::*;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  src;
    logic [1:0]    cfg_addr;
    logic          cfg_we;
    logic          cfg_re;
    logic [31:0]   cfg_wdata;
    logic [31:0]   cfg_rdata;
    logic          eoi;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    typedef struct {
        string       name;
        logic [7:0]  src;
        logic        we;
        logic        re;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        eoi;
        logic        chk_irq;
        logic        exp_irq;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    irq_controller #(.NUM_SRC(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .src       (src),
        .cfg_addr  (cfg_addr),
        .cfg_we    (cfg_we),
        .cfg_re    (cfg_re),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .eoi       (eoi),
        .irq       (irq)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cfg_we    = 1'b0;
        cfg_re    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = 32'd0;
        eoi       = 1'b0;
    endtask

    task automatic pop_read();
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: got read with empty queue required queued entry");
        end else begin
            string nm;
            logic [31:0] ex;
            nm = tag_q.pop_front();
            ex = exp_q.pop_front();
            check(nm, cfg_rdata, ex);
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        src   = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        cfg_addr  = addr;
        cfg_wdata = data;
        cfg_we    = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic cfg_read(input logic [1:0] addr, input logic [31:0] exp, input string name);
        cfg_addr = addr;
        cfg_re   = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(name);
        tick();
        idle_inputs();
        pop_read();
    endtask

    task automatic pulse_src(input logic [7:0] s);
        src = s;
        tick();
        tick();
        tick();
        src = '0;
    endtask

    task automatic wait_irq(input int budget, input string name);
        int n;
        n = 0;
        while (!irq && n < budget) begin
            tick();
            n++;
        end
        check(name, {31'd0, irq}, 32'd1);
    endtask

    task automatic add(input string name, input logic [7:0] s, input logic we, input logic re,
                       input logic [1:0] addr, input logic [31:0] wdata, input logic e,
                       input logic chk_irq, input logic exp_irq, input logic [31:0] exp_rd);
        vec_t v;
        v.name    = name;
        v.src     = s;
        v.we      = we;
        v.re      = re;
        v.addr    = addr;
        v.wdata   = wdata;
        v.eoi     = e;
        v.chk_irq = chk_irq;
        v.exp_irq = exp_irq;
        v.exp_rd  = exp_rd;
        vecs.push_back(v);
    endtask

    function automatic int lowest(input logic [7:0] v);
        int r;
        r = 0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    logic [7:0] rm;
    logic [7:0] rs;
    logic [7:0] re_v;

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        check("reset irq", {31'd0, irq}, 32'd0);
        check("reset rdata", cfg_rdata, 32'd0);
        cfg_read(ADDR_MASK, 32'd0, "reset mask");
        cfg_read(ADDR_PENDING, 32'd0, "reset pending");
        cfg_read(ADDR_STATUS, 32'd0, "reset status");
        cfg_read(ADDR_CLAIM, 32'd0, "reset claim");

        // ---------------- table of per-cycle vectors ----------------
        //   name          src    we re addr          wdata  eoi chk irq rd
        add("t1 mask",     8'h00, 1, 0, ADDR_MASK,    32'h05, 0, 1, 0, 0);
        add("t1 src k",    8'h04, 0, 0, ADDR_MASK,    32'h00, 0, 1, 0, 0);
        add("t1 src k1",   8'h04, 0, 0, ADDR_MASK,    32'h00, 0, 1, 0, 0);
        add("t1 src k2",   8'h04, 0, 0, ADDR_MASK,    32'h00, 0, 1, 0, 0);
        add("t1 pend",     8'h00, 0, 1, ADDR_PENDING, 32'h00, 0, 1, 1, 32'h04);
        add("t1 claim",    8'h00, 0, 1, ADDR_CLAIM,   32'h00, 0, 1, 0, 32'd3);
        add("t1 status",   8'h00, 0, 1, ADDR_STATUS,  32'h00, 0, 1, 0, 32'h0E);
        add("t1 pend clr", 8'h00, 0, 1, ADDR_PENDING, 32'h00, 0, 1, 0, 32'h00);
        add("t1 eoi",      8'h00, 0, 0, ADDR_MASK,    32'h00, 1, 1, 0, 0);
        add("t1 st idle",  8'h00, 0, 1, ADDR_STATUS,  32'h00, 0, 1, 0, 32'h00);
        add("t2 mask src", 8'h05, 1, 0, ADDR_MASK,    32'hFF, 0, 1, 0, 0);
        add("t2 src k1",   8'h05, 0, 0, ADDR_MASK,    32'h00, 0, 1, 0, 0);
        add("t2 src k2",   8'h05, 0, 0, ADDR_MASK,    32'h00, 0, 1, 0, 0);
        add("t2 irq",      8'h00, 0, 0, ADDR_MASK,    32'h00, 0, 1, 1, 0);
        add("t2 claim1",   8'h00, 0, 1, ADDR_CLAIM,   32'h00, 0, 1, 0, 32'd1);
        add("t2 eoi1",     8'h00, 0, 0, ADDR_MASK,    32'h00, 1, 1, 0, 0);
        add("t2 reraise",  8'h00, 0, 0, ADDR_MASK,    32'h00, 0, 1, 1, 0);
        add("t2 claim2",   8'h00, 0, 1, ADDR_CLAIM,   32'h00, 0, 1, 0, 32'd3);
        add("t2 eoi2",     8'h00, 0, 0, ADDR_MASK,    32'h00, 1, 1, 0, 0);
        add("t2 claim0",   8'h00, 0, 1, ADDR_CLAIM,   32'h00, 0, 1, 0, 32'd0);
        add("t3 mask0",    8'h20, 1, 0, ADDR_MASK,    32'h00, 0, 1, 0, 0);
        add("t3 src k1",   8'h20, 0, 0, ADDR_MASK,    32'h00, 0, 1, 0, 0);
        add("t3 src k2",   8'h20, 0, 0, ADDR_MASK,    32'h00, 0, 1, 0, 0);
        add("t3 pend",     8'h00, 0, 1, ADDR_PENDING, 32'h00, 0, 1, 0, 32'h20);
        add("t3 quiet",    8'h00, 0, 0, ADDR_MASK,    32'h00, 0, 1, 0, 0);
        add("t3 unmask",   8'h00, 1, 0, ADDR_MASK,    32'h20, 0, 1, 0, 0);
        add("t3 irq",      8'h00, 0, 0, ADDR_MASK,    32'h00, 0, 1, 1, 0);
        add("t4 w1c",      8'h00, 1, 0, ADDR_PENDING, 32'h20, 0, 0, 0, 0);
        add("t4 irq low",  8'h00, 0, 0, ADDR_MASK,    32'h00, 0, 1, 0, 0);
        add("t4 pend",     8'h00, 0, 1, ADDR_PENDING, 32'h00, 0, 1, 0, 32'h00);
        add("t4 status",   8'h00, 0, 1, ADDR_STATUS,  32'h00, 0, 1, 0, 32'h00);
        add("t4 claim0",   8'h00, 0, 1, ADDR_CLAIM,   32'h00, 0, 1, 0, 32'd0);
        add("t5 src k",    8'h02, 0, 0, ADDR_MASK,    32'h00, 0, 1, 0, 0);
        add("t5 src k1",   8'h02, 0, 0, ADDR_MASK,    32'h00, 0, 1, 0, 0);
        add("t5 w1c race", 8'h02, 1, 0, ADDR_PENDING, 32'h02, 0, 1, 0, 0);
        add("t5 set wins", 8'h00, 0, 1, ADDR_PENDING, 32'h00, 0, 1, 0, 32'h02);
        add("t5 w1c",      8'h00, 1, 0, ADDR_PENDING, 32'h02, 0, 1, 0, 0);
        add("t5 cleared",  8'h00, 0, 1, ADDR_PENDING, 32'h00, 0, 1, 0, 32'h00);

        foreach (vecs[i]) begin
            src       = vecs[i].src;
            cfg_we    = vecs[i].we;
            cfg_re    = vecs[i].re;
            cfg_addr  = vecs[i].addr;
            cfg_wdata = vecs[i].wdata;
            eoi       = vecs[i].eoi;
            if (vecs[i].re) begin
                exp_q.push_back(vecs[i].exp_rd);
                tag_q.push_back(vecs[i].name);
            end
            tick();
            if (vecs[i].chk_irq) begin
                check($sformatf("%s irq", vecs[i].name), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
            end
            if (vecs[i].re) begin
                pop_read();
            end
        end
        idle_inputs();
        src = '0;

        // ---------------- reset mid-handshake ----------------
        do_reset();
        cfg_write(ADDR_MASK, 32'hFF);
        pulse_src(8'h08);
        wait_irq(10, "t6 raise");
        cfg_read(ADDR_CLAIM, 32'd4, "t6 claim");
        cfg_read(ADDR_STATUS, 32'h12, "t6 status claimed");
        pulse_src(8'h40);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6 rst irq", {31'd0, irq}, 32'd0);
        check("t6 rst rdata", cfg_rdata, 32'd0);
        cfg_read(ADDR_MASK, 32'd0, "t6 rst mask");
        cfg_read(ADDR_PENDING, 32'd0, "t6 rst pending");
        cfg_read(ADDR_STATUS, 32'd0, "t6 rst status");
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        check("t6 stray eoi irq", {31'd0, irq}, 32'd0);
        cfg_read(ADDR_STATUS, 32'd0, "t6 stray eoi status");

        // ---------------- randomised mask/source priority ----------------
        for (int it = 0; it < 6; it++) begin
            rm = 8'($urandom_range(0, 255));
            rs = 8'($urandom_range(1, 255));
            re_v = rs & rm;
            do_reset();
            cfg_write(ADDR_MASK, {24'd0, rm});
            pulse_src(rs);
            tick();
            check($sformatf("rnd%0d irq", it), {31'd0, irq}, {31'd0, (re_v != 8'd0)});
            cfg_read(ADDR_PENDING, {24'd0, rs}, $sformatf("rnd%0d pending", it));
            if (re_v != 8'd0) begin
                cfg_read(ADDR_CLAIM, 32'(lowest(re_v) + 1), $sformatf("rnd%0d claim", it));
                check($sformatf("rnd%0d irq drop", it), {31'd0, irq}, 32'd0);
                cfg_read(ADDR_PENDING, {24'd0, rs & ~(8'd1 << lowest(re_v))},
                         $sformatf("rnd%0d pending after claim", it));
            end
        end

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller that collects up to NUM_SRC asynchronous peripheral interrupt sources and sequences them onto one CPU interrupt line feeding a PC interrupt input (int1). It synchronises and edge-detects each source, latches pending requests, applies a software mask and fixed priority, and runs a raise/claim/end-of-interrupt handshake with the CPU. The CPU configures and services it through a small memory-mapped register port.

## Interface
- NUM_SRC, 8, number of interrupt sources (1..31)
- clk  in  1  system clock, posedge
- reset  in  1  reset, synchronous, active-high
- src  in  NUM_SRC  raw interrupt sources, asynchronous, rising-edge triggered
- cfg_addr  in  2  register select: 0 MASK, 1 PENDING, 2 CLAIM, 3 STATUS
- cfg_we  in  1  write strobe, one cycle
- cfg_re  in  1  read strobe, one cycle; ignored when cfg_we is also high
- cfg_wdata  in  32  write data
- cfg_rdata  out  32  registered read data
- eoi  in  1  end-of-interrupt pulse, driven from the CPU reti decode
- irq  out  1  interrupt request to the PC, registered level

## Operation
- Per source: 2-flop synchroniser, then a third flop; rising edge = sync2 & ~sync3.
- Edge sets pending[i]. If a set and a clear hit the same bit in the same cycle, the set wins.
- Eligible = pending & mask. Priority is fixed: lowest index wins.
- MASK (rw): bits [NUM_SRC-1:0] enable sources; upper bits read 0. Masking leaves pending unchanged.
- PENDING: reads the pending vector. Writing 1 to a bit clears it (W1C); writing 0 has no effect.
- CLAIM (read only): returns winner index+1, or 0 when nothing is eligible.
  - A nonzero claim clears that pending bit and records the index as in_service.
  - A claim in IDLE returns the id without changing state.
- STATUS (ro): [1:0] state, [7:2] in_service id+1 (0 if none), [8] irq.
- Writes to CLAIM or STATUS are ignored.
- FSM states, encoded IDLE=0, RAISE=1, CLAIMED=2:
  - IDLE -> RAISE when eligible != 0; irq <= 1.
  - RAISE -> CLAIMED on a nonzero CLAIM read; irq <= 0.
  - RAISE -> IDLE if eligible becomes 0 through a mask change or W1C; irq <= 0.
  - CLAIMED -> IDLE on eoi; in_service cleared.
  - eoi in IDLE or RAISE is ignored.
  - No new raise occurs while CLAIMED; nesting is not supported.
- Reset clears sync flops, pending, mask, in_service and cfg_rdata to 0, sets state to IDLE and irq to 0. This applies mid-handshake too: no pending survives reset.

## Timing
- src high before edge k: pending visible after edge k+2, irq high after edge k+3 (if masked in, state IDLE).
- cfg_rdata is valid the cycle after cfg_re and holds until the next read.
- CLAIM side effects (pending clear, state, irq drop) take effect at the same edge that captures cfg_rdata.
- After eoi at edge e, irq can be high again after edge e+1 if eligible != 0. This guarantees at least one low cycle, so the PC sees a fresh rising edge.
- The minimum irq-low gap between consecutive requests is 1 cycle.
- A MASK write takes effect on eligibility the next cycle.
- A source pulse shorter than one clk period may be missed. Sources must hold for at least 2 cycles.

## Structure
- irq_pkg holds:
  - register address constants MASK/PENDING/CLAIM/STATUS
  - state enum IDLE/RAISE/CLAIMED
  - STATUS field offsets
- Sub-module irq_sync_edge holds the synchroniser and edge detect for one source (1-bit in, 1-bit rise pulse). It is instantiated NUM_SRC times via generate.
- Priority encoder, register file and FSM live in irq_controller.

## Test plan
- Reset, then MASK=0x05, pulse src[2] for 3 cycles -> pending=0x04, irq high 3 cycles after the edge, CLAIM reads 3, irq drops, STATUS state=2.
- src[0] and src[2] rise together, MASK=0xFF -> first CLAIM=1; eoi; irq low ≥1 cycle then high; second CLAIM=3; after eoi, CLAIM=0.
- MASK=0, src[5] rises -> pending=0x20, irq stays 0; write MASK=0x20 -> irq high the cycle after next.
- RAISE state, write PENDING=0x20 (W1C) -> pending=0, irq low, state IDLE; CLAIM reads 0.
- W1C on a bit in the same cycle that its source edge arrives -> bit remains 1.
- RAISE then CLAIMED, assert reset -> irq=0, pending=0, mask=0, state IDLE; a stray eoi afterwards causes no change.
